// File: rtl/pc_seq_unit_if.sv
// Control strobes in, program-counter results out, between decode/ALU and the PC unit.
interface pc_seq_unit_if #(
    parameter int ADDR_W = 32
);
    logic              i_stall;
    logic [25:0]       i_imm;
    logic              i_jump;
    logic              i_jal;
    logic              i_jr;
    logic              i_ret;
    logic [ADDR_W-1:0] i_rs_val;
    logic              i_beq;
    logic              i_bne;
    logic              i_zerof;
    logic [ADDR_W-1:0] o_pc;
    logic [ADDR_W-1:0] o_nextpc;
    logic [ADDR_W-1:0] o_link;
    logic              o_pcsrc;
    logic              o_ras_empty;
    logic              o_ras_full;

    // Driver side: decode/ALU control and the register-file rs value.
    modport master (
        output i_stall, i_imm, i_jump, i_jal, i_jr, i_ret, i_rs_val, i_beq, i_bne, i_zerof,
        input  o_pc, o_nextpc, o_link, o_pcsrc, o_ras_empty, o_ras_full
    );

    // PC unit side.
    modport slave (
        input  i_stall, i_imm, i_jump, i_jal, i_jr, i_ret, i_rs_val, i_beq, i_bne, i_zerof,
        output o_pc, o_nextpc, o_link, o_pcsrc, o_ras_empty, o_ras_full
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter unit: PC register, next-PC selection (ret/jr/jump/branch)
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_seq_unit #(
    parameter int          ADDR_W    = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input logic           i_clk,
    input logic           i_rst,
    pc_seq_unit_if.slave  bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // top_q indexes the next free slot; the live top entry sits at top_q - 1.
    logic [PTR_W-1:0]  top_q, top_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

    logic [ADDR_W-1:0] pc4, btgt, jtgt, rtgt, boff, nextpc;
    logic [PTR_W-1:0]  top_idx;
    logic              pcsrc, ras_empty, ras_full;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    // Candidate targets and priority selection of the next PC.
    always_comb begin
        pc4     = pc_q + ADDR_W'(4);
        boff    = {{(ADDR_W-16){bus.i_imm[15]}}, bus.i_imm[15:0]};
        btgt    = pc4 + (boff << 2);
        jtgt    = {pc4[ADDR_W-1:28], bus.i_imm, 2'b00};
        top_idx = top_q - PTR_W'(1);
        rtgt    = ras_empty ? bus.i_rs_val : ras_q[top_idx];
        nextpc  = pc4;
        pcsrc   = 1'b1;
        if (bus.i_ret) begin
            nextpc = rtgt;
        end else if (bus.i_jr) begin
            nextpc = bus.i_rs_val;
        end else if (bus.i_jump || bus.i_jal) begin
            nextpc = jtgt;
        end else if ((bus.i_beq && bus.i_zerof) || (bus.i_bne && !bus.i_zerof)) begin
            nextpc = btgt;
        end else begin
            pcsrc  = 1'b0;
        end
    end

    // Next-state for PC and RAS; a stall leaves everything untouched.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        top_d = top_q;
        ras_d = ras_q;
        if (!bus.i_stall) begin
            pc_d = nextpc;
            if (bus.i_jal && (!bus.i_ret || ras_empty)) begin
                // Push; when full the write lands on the oldest slot and count saturates.
                ras_d[top_q] = pc4;
                top_d        = top_q + PTR_W'(1);
                if (!ras_full) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (bus.i_jal && bus.i_ret) begin
                // Call and return together: replace the top entry in place.
                ras_d[top_idx] = pc4;
            end else if (bus.i_ret && !ras_empty) begin
                top_d = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; reset clears PC and stack bookkeeping, entries need no reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q  <= ADDR_W'(RESET_VEC);
            cnt_q <= '0;
            top_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
        end
        ras_q <= ras_d;
    end

    assign bus.o_pc        = pc_q;
    assign bus.o_nextpc    = nextpc;
    assign bus.o_link      = pc4;
    assign bus.o_pcsrc     = pcsrc;
    assign bus.o_ras_empty = ras_empty;
    assign bus.o_ras_full  = ras_full;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_pc_seq_unit;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0400;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_seq_unit_if #(.ADDR_W(AW)) bus ();

    pc_seq_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_VEC(RV)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Reference model: architectural PC and the stack as a queue (back = top).
    logic [31:0] m_pc;
    logic [31:0] ras_m [$];

    function automatic logic [31:0] m_next(output logic src);
        logic [31:0] pc4;
        pc4 = m_pc + 32'd4;
        src = 1'b1;
        if (bus.i_ret)                   return (ras_m.size() > 0) ? ras_m[ras_m.size()-1] : bus.i_rs_val;
        if (bus.i_jr)                    return bus.i_rs_val;
        if (bus.i_jump || bus.i_jal)     return {pc4[31:28], bus.i_imm, 2'b00};
        if ((bus.i_beq && bus.i_zerof) || (bus.i_bne && !bus.i_zerof))
            return pc4 + 32'($signed(bus.i_imm[15:0])) * 32'd4;
        src = 1'b0;
        return pc4;
    endfunction

    always @(posedge clk) begin
        logic [31:0] nxt, pc4;
        logic        s;
        if (rst) begin
            m_pc = RV;
            ras_m.delete();
        end else if (!bus.i_stall) begin
            nxt = m_next(s);
            pc4 = m_pc + 32'd4;
            if (bus.i_jal && bus.i_ret) begin
                if (ras_m.size() > 0) ras_m[ras_m.size()-1] = pc4;
                else                  ras_m.push_back(pc4);
            end else if (bus.i_jal) begin
                if (ras_m.size() == DEPTH) void'(ras_m.pop_front());
                ras_m.push_back(pc4);
            end else if (bus.i_ret && ras_m.size() > 0) begin
                void'(ras_m.pop_back());
            end
            m_pc = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] enx;
        logic        esrc;
        if (chk_en) begin
            enx = m_next(esrc);
            chk("o_pc",        bus.o_pc,     m_pc);
            chk("o_nextpc",    bus.o_nextpc, enx);
            chk("o_link",      bus.o_link,   m_pc + 32'd4);
            chk("o_pcsrc",     {31'd0, bus.o_pcsrc},     {31'd0, esrc});
            chk("o_ras_empty", {31'd0, bus.o_ras_empty}, {31'd0, ras_m.size() == 0});
            chk("o_ras_full",  {31'd0, bus.o_ras_full},  {31'd0, ras_m.size() == DEPTH});
        end
    end

    task automatic clr();
        bus.i_stall = 0; bus.i_imm = '0; bus.i_jump = 0; bus.i_jal = 0; bus.i_jr = 0;
        bus.i_ret = 0; bus.i_rs_val = '0; bus.i_beq = 0; bus.i_bne = 0; bus.i_zerof = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] exp_ret [4] = '{32'h1000_1004, 32'h1000_0C04, 32'h1000_0804, 32'h1000_0404};

    initial begin
        clr();
        rst = 1'b1;
        step(1);
        chk_en = 1'b1;
        chk("rst_pc", bus.o_pc, 32'h400);
        chk("rst_empty", {31'd0, bus.o_ras_empty}, 32'd1);
        chk("rst_full", {31'd0, bus.o_ras_full}, 32'd0);
        rst = 1'b0;
        step(1); chk("seq_404", bus.o_pc, 32'h404);
        step(1); chk("seq_408", bus.o_pc, 32'h408);
        step(1); chk("seq_40c", bus.o_pc, 32'h40C);
        chk("seq_pcsrc", {31'd0, bus.o_pcsrc}, 32'd0);

        // Branches around 0x1000
        bus.i_jump = 1; bus.i_imm = 26'h400; step(1); clr();
        chk("j_1000", bus.o_pc, 32'h1000);
        bus.i_beq = 1; bus.i_zerof = 1; bus.i_imm = 26'h000FFFF; #1;
        chk("beq_back_nx", bus.o_nextpc, 32'h1000);
        step(1);
        chk("beq_back_pc", bus.o_pc, 32'h1000);
        bus.i_zerof = 0; #1;
        chk("beq_nt_nx", bus.o_nextpc, 32'h1004);
        bus.i_beq = 0; bus.i_bne = 1; bus.i_imm = 26'd3; #1;
        chk("bne_nx", bus.o_nextpc, 32'h1010);
        step(1); clr();
        chk("bne_pc", bus.o_pc, 32'h1010);

        // jal then ret
        bus.i_jr = 1; bus.i_rs_val = 32'h1000_0010; step(1); clr();
        bus.i_jal = 1; bus.i_imm = 26'h40; step(1); clr();
        chk("jal_pc", bus.o_pc, 32'h1000_0100);
        chk("jal_nonempty", {31'd0, bus.o_ras_empty}, 32'd0);
        bus.i_ret = 1; bus.i_rs_val = 32'hDEAD; step(1); clr();
        chk("ret_pc", bus.o_pc, 32'h1000_0014);
        chk("ret_empty", {31'd0, bus.o_ras_empty}, 32'd1);

        // Overflow: five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            bus.i_jal = 1; bus.i_imm = 26'(i * 32'h100); step(1); clr();
        end
        chk("ovf_full", {31'd0, bus.o_ras_full}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.i_ret = 1; bus.i_rs_val = 32'h7777; step(1); clr();
            chk("ovf_ret", bus.o_pc, exp_ret[i]);
        end
        chk("ovf_empty", {31'd0, bus.o_ras_empty}, 32'd1);
        bus.i_ret = 1; bus.i_rs_val = 32'h2000; step(1); clr();
        chk("under_pc", bus.o_pc, 32'h2000);
        chk("under_empty", {31'd0, bus.o_ras_empty}, 32'd1);

        // Stalled jal
        bus.i_jal = 1; bus.i_imm = 26'h900; bus.i_stall = 1; #1;
        chk("stall_nx", bus.o_nextpc, 32'h2400);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_pc", bus.o_pc, 32'h2000);
            chk("stall_empty", {31'd0, bus.o_ras_empty}, 32'd1);
        end
        bus.i_stall = 0; step(1); clr();
        chk("unstall_pc", bus.o_pc, 32'h2400);
        bus.i_ret = 1; step(1); clr();
        chk("unstall_ret", bus.o_pc, 32'h2004);
        chk("unstall_empty", {31'd0, bus.o_ras_empty}, 32'd1);

        // Priority cases
        bus.i_jump = 1; bus.i_beq = 1; bus.i_zerof = 1; bus.i_imm = 26'h10; #1;
        chk("j_over_beq", bus.o_nextpc, 32'h40);
        step(1); clr();
        bus.i_jal = 1; bus.i_imm = 26'h20; step(1); clr();
        chk("jal_80", bus.o_pc, 32'h80);
        bus.i_ret = 1; bus.i_jr = 1; bus.i_rs_val = 32'h3000; #1;
        chk("ret_over_jr", bus.o_nextpc, 32'h44);
        step(1); clr();
        chk("ret_over_jr_pc", bus.o_pc, 32'h44);
        bus.i_jal = 1; bus.i_ret = 1; bus.i_rs_val = 32'h500; step(1); clr();
        chk("jalret_empty_pc", bus.o_pc, 32'h500);
        bus.i_ret = 1; step(1); clr();
        chk("jalret_empty_push", bus.o_pc, 32'h48);
        bus.i_jal = 1; bus.i_imm = 26'h100; step(1); clr();
        bus.i_jal = 1; bus.i_ret = 1; bus.i_imm = 26'h3; bus.i_rs_val = 32'h9999; step(1); clr();
        chk("jalret_pc", bus.o_pc, 32'h4C);
        bus.i_ret = 1; step(1); clr();
        chk("jalret_replace", bus.o_pc, 32'h404);
        chk("jalret_empty", {31'd0, bus.o_ras_empty}, 32'd1);

        // Wrap at the top of the address space
        bus.i_jr = 1; bus.i_rs_val = 32'hFFFF_FFFC; step(1); clr(); #1;
        chk("wrap_nx", bus.o_nextpc, 32'h0);
        step(1);
        chk("wrap_pc", bus.o_pc, 32'h0);

        // Reset during a stall
        bus.i_jal = 1; bus.i_imm = 26'h55; bus.i_stall = 1; step(1);
        rst = 1'b1; step(1);
        chk("rst_stall_pc", bus.o_pc, 32'h400);
        chk("rst_stall_empty", {31'd0, bus.o_ras_empty}, 32'd1);
        rst = 1'b0; clr(); step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
